// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared definitions for the counter bank.
//   mode_e       - per-channel overflow behaviour (wrap or saturate)
//   DEFAULT_*    - default bank geometry
//   slice_lo()   - low bit index of channel ch in a packed NUM_CH*WIDTH bus
package counter_bank_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int DEFAULT_NUM_CH = 4;
    localparam int DEFAULT_WIDTH  = 8;
    localparam int MAX_NUM_CH     = 32;

    function automatic int slice_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// counter_ch: one counter channel with registered count and terminal-count pulse.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   en                  - global enable (clear ignores it)
//   clear, load, inc, dec - per-channel requests, priority clear > load > inc^dec
//   load_val, max_val   - load value and terminal value
//   mode                - MODE_WRAP or MODE_SAT
//   count, tc           - registered count and one-cycle terminal-count pulse
//   tc_next             - next-state tc, used by the top for the expiry encoder
module counter_ch
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] max_val,
    input  mode_e            mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             tc_next
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            if (load) begin
                count_d = (load_val < max_val) ? load_val : max_val;
            end else if (inc && !dec) begin
                // Compare before incrementing so count never passes through an overflow.
                if (count_q < max_val) begin
                    count_d = count_q + ONE;
                    // Saturate mode flags the first arrival at max_val.
                    tc_d    = (mode == MODE_SAT) && (count_q == max_val - ONE);
                end else if (mode == MODE_WRAP) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    // Already at (or above a lowered) max: pin to max, no new event.
                    count_d = max_val;
                end
            end else if (dec && !inc) begin
                if (count_q == '0) begin
                    if (mode == MODE_WRAP) begin
                        count_d = max_val;
                        tc_d    = 1'b1;
                    end
                end else if (count_q > max_val) begin
                    count_d = max_val;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign tc_next = tc_d;

endmodule

// File: rtl/counter_bank.sv
// counter_bank: NUM_CH independent up/down counters with wrap/saturate modes and
// a registered lowest-index expiry encoder.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   en                    - global enable
//   clear, load, inc, dec - per-channel request vectors
//   load_val, max_val     - packed per-channel values, channel i at [i*WIDTH +: WIDTH]
//   sat_mode              - per-channel mode (0 wrap, 1 saturate)
//   count, tc             - packed registered counts and terminal-count pulses
//   exp_valid, exp_idx    - any tc high / lowest channel index with tc high
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       clear,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [NUM_CH-1:0]       inc,
    input  logic [NUM_CH-1:0]       dec,
    input  logic [NUM_CH*WIDTH-1:0] max_val,
    input  logic [NUM_CH-1:0]       sat_mode,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       tc,
    output logic                    exp_valid,
    output logic [IDX_W-1:0]        exp_idx
);

    logic [NUM_CH-1:0] tc_next;
    logic              exp_valid_q, exp_valid_d;
    logic [IDX_W-1:0]  exp_idx_q, exp_idx_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int LO = slice_lo(i, WIDTH);

        counter_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .clear    (clear[i]),
            .load     (load[i]),
            .load_val (load_val[LO +: WIDTH]),
            .inc      (inc[i]),
            .dec      (dec[i]),
            .max_val  (max_val[LO +: WIDTH]),
            .mode     (mode_e'(sat_mode[i])),
            .count    (count[LO +: WIDTH]),
            .tc       (tc[i]),
            .tc_next  (tc_next[i])
        );
    end

    // Fixed priority: scanning downward lets the lowest set index win.
    always_comb begin
        exp_valid_d = |tc_next;
        exp_idx_d   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (tc_next[i]) begin
                exp_idx_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_valid_q <= 1'b0;
            exp_idx_q   <= '0;
        end else begin
            exp_valid_q <= exp_valid_d;
            exp_idx_q   <= exp_idx_d;
        end
    end

    assign exp_valid = exp_valid_q;
    assign exp_idx   = exp_idx_q;

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed scenarios plus randomized traffic checked against a
// behavioural model of the counter rules.
module tb_counter_bank;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int IDX_W  = 2;

    logic                    clk;
    logic                    rst;
    logic                    en;
    logic [NUM_CH-1:0]       clear;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*WIDTH-1:0] load_val;
    logic [NUM_CH-1:0]       inc;
    logic [NUM_CH-1:0]       dec;
    logic [NUM_CH*WIDTH-1:0] max_val;
    logic [NUM_CH-1:0]       sat_mode;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       tc;
    logic                    exp_valid;
    logic [IDX_W-1:0]        exp_idx;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_cnt[NUM_CH];
    bit m_tc[NUM_CH];
    bit m_ev;
    int m_idx;

    counter_bank #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clear     (clear),
        .load      (load),
        .load_val  (load_val),
        .inc       (inc),
        .dec       (dec),
        .max_val   (max_val),
        .sat_mode  (sat_mode),
        .count     (count),
        .tc        (tc),
        .exp_valid (exp_valid),
        .exp_idx   (exp_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0;
            m_tc[c]  = 0;
        end
        m_ev  = 0;
        m_idx = 0;
    endtask

    // Applies the counter rules to the currently driven inputs.
    task automatic model_step();
        m_ev  = 0;
        m_idx = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            int v;
            int mx;
            int lv;
            bit t;
            v  = m_cnt[c];
            mx = int'(max_val[c*WIDTH +: WIDTH]);
            lv = int'(load_val[c*WIDTH +: WIDTH]);
            t  = 0;
            if (clear[c]) begin
                v = 0;
            end else if (en) begin
                if (load[c]) begin
                    v = (lv < mx) ? lv : mx;
                end else if (inc[c] && !dec[c]) begin
                    if (sat_mode[c]) begin
                        if (v < mx) begin
                            v = v + 1;
                            t = (v == mx);
                        end else begin
                            v = mx;
                        end
                    end else if (v >= mx) begin
                        v = 0;
                        t = 1;
                    end else begin
                        v = v + 1;
                    end
                end else if (dec[c] && !inc[c]) begin
                    if (v == 0) begin
                        if (!sat_mode[c]) begin
                            v = mx;
                            t = 1;
                        end
                    end else if (v > mx) begin
                        v = mx;
                    end else begin
                        v = v - 1;
                    end
                end
            end
            m_cnt[c] = v;
            m_tc[c]  = t;
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (m_tc[c]) begin
                m_ev  = 1;
                m_idx = c;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en    = 1'b1;
        clear = '0;
        load  = '0;
        inc   = '0;
        dec   = '0;
    endtask

    task automatic set_max(input int c, input int v);
        max_val[c*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic set_ld(input int c, input int v);
        load_val[c*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic test_reset();
        n_tests++;
        if (count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %h expected 0", count);
        end
        n_tests++;
        if (tc !== '0) begin
            n_fail++;
            $display("FAIL reset_tc: got %b expected 0", tc);
        end
        n_tests++;
        if (exp_valid !== 1'b0 || exp_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_exp: got %b/%0d expected 0/0", exp_valid, exp_idx);
        end
    endtask

    task automatic test_wrap_up();
        int exp_c[4];
        bit exp_t[4];
        exp_c = '{1, 2, 3, 0};
        exp_t = '{0, 0, 0, 1};
        idle();
        clear = '1;
        cycle();
        idle();
        sat_mode[0] = 1'b0;
        set_max(0, 3);
        inc[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_tests++;
            if (count[7:0] !== 8'(exp_c[k]) || tc[0] !== exp_t[k]) begin
                n_fail++;
                $display("FAIL wrap_up_%0d: got count %0d tc %b expected %0d %b",
                         k, count[7:0], tc[0], exp_c[k], exp_t[k]);
            end
        end
        n_tests++;
        if (exp_valid !== 1'b1 || exp_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_up_exp: got %b/%0d expected 1/0", exp_valid, exp_idx);
        end
        idle();
    endtask

    task automatic test_saturate();
        int  exp_c[3];
        bit  exp_t[3];
        exp_c = '{5, 5, 5};
        exp_t = '{1, 0, 0};
        idle();
        sat_mode[1] = 1'b1;
        set_max(1, 5);
        set_ld(1, 4);
        load[1] = 1'b1;
        cycle();
        n_tests++;
        if (count[15:8] !== 8'd4 || tc[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_load: got %0d tc %b expected 4 0", count[15:8], tc[1]);
        end
        load[1] = 1'b0;
        inc[1]  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_tests++;
            if (count[15:8] !== 8'(exp_c[k]) || tc[1] !== exp_t[k]) begin
                n_fail++;
                $display("FAIL sat_inc_%0d: got %0d tc %b expected %0d %b",
                         k, count[15:8], tc[1], exp_c[k], exp_t[k]);
            end
        end
        inc[1] = 1'b0;
        dec[1] = 1'b1;
        cycle();
        n_tests++;
        if (count[15:8] !== 8'd4 || tc[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_dec: got %0d tc %b expected 4 0", count[15:8], tc[1]);
        end
        idle();
    endtask

    task automatic test_wrap_down();
        idle();
        sat_mode[2] = 1'b0;
        set_max(2, 9);
        clear[2] = 1'b1;
        cycle();
        idle();
        dec[2] = 1'b1;
        cycle();
        n_tests++;
        if (count[23:16] !== 8'd9 || tc[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_down: got %0d tc %b expected 9 1", count[23:16], tc[2]);
        end
        inc[2] = 1'b1;
        cycle();
        n_tests++;
        if (count[23:16] !== 8'd9 || tc[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_dec_hold: got %0d tc %b expected 9 0", count[23:16], tc[2]);
        end
        idle();
    endtask

    task automatic test_simultaneous_tc();
        idle();
        sat_mode = '0;
        set_max(1, 2);
        set_ld(1, 2);
        set_max(3, 4);
        set_ld(3, 4);
        load = 4'b1010;
        cycle();
        idle();
        inc = 4'b1010;
        cycle();
        n_tests++;
        if (tc !== 4'b1010 || exp_valid !== 1'b1 || exp_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL multi_tc: got tc %b exp %b/%0d expected 1010 1/1",
                     tc, exp_valid, exp_idx);
        end
        idle();
        cycle();
        n_tests++;
        if (tc !== 4'b0000 || exp_valid !== 1'b0 || exp_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL multi_tc_clear: got tc %b exp %b/%0d expected 0000 0/0",
                     tc, exp_valid, exp_idx);
        end
    endtask

    task automatic test_load_clear_en();
        idle();
        set_max(0, 100);
        set_ld(0, 200);
        load[0] = 1'b1;
        cycle();
        n_tests++;
        if (count[7:0] !== 8'd100) begin
            n_fail++;
            $display("FAIL load_clamp: got %0d expected 100", count[7:0]);
        end
        clear[0] = 1'b1;
        cycle();
        n_tests++;
        if (count[7:0] !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_over_load: got %0d expected 0", count[7:0]);
        end
        clear[0] = 1'b0;
        set_ld(0, 50);
        cycle();
        load[0] = 1'b0;
        en      = 1'b0;
        inc[0]  = 1'b1;
        cycle();
        n_tests++;
        if (count[7:0] !== 8'd50 || tc[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL en_low_hold: got %0d tc %b expected 50 0", count[7:0], tc[0]);
        end
        inc[0]   = 1'b0;
        clear[0] = 1'b1;
        cycle();
        n_tests++;
        if (count[7:0] !== 8'd0) begin
            n_fail++;
            $display("FAIL en_low_clear: got %0d expected 0", count[7:0]);
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        sat_mode[0] = 1'b0;
        set_max(0, 7);
        set_ld(0, 7);
        load[0] = 1'b1;
        cycle();
        n_tests++;
        if (count[7:0] !== 8'd7) begin
            n_fail++;
            $display("FAIL rst_setup: got %0d expected 7", count[7:0]);
        end
        // Pending inc at max would wrap with tc on the next edge.
        load[0] = 1'b0;
        inc[0]  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (count[7:0] !== 8'd0 || tc !== '0 || exp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got %0d tc %b ev %b expected 0 0000 0",
                     count[7:0], tc, exp_valid);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (count !== '0 || tc !== '0 || exp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_edge: got %h tc %b ev %b expected 0 0000 0",
                     count, tc, exp_valid);
        end
        rst = 1'b0;
        model_reset();
        idle();
    endtask

    task automatic test_random();
        logic [NUM_CH*WIDTH-1:0] exp_count;
        logic [NUM_CH-1:0]       exp_tc;
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 7) != 0);
            for (int c = 0; c < NUM_CH; c++) begin
                clear[c]    = ($urandom_range(0, 15) == 0);
                load[c]     = ($urandom_range(0, 7) == 0);
                inc[c]      = $urandom_range(0, 1) == 1;
                dec[c]      = $urandom_range(0, 1) == 1;
                sat_mode[c] = $urandom_range(0, 1) == 1;
                set_ld(c, int'($urandom_range(0, 255)));
                if ($urandom_range(0, 7) == 0) begin
                    set_max(c, int'($urandom_range(0, 255)));
                end else if ($urandom_range(0, 3) == 0) begin
                    set_max(c, int'($urandom_range(0, 6)));
                end
            end
            cycle();
            for (int c = 0; c < NUM_CH; c++) begin
                exp_count[c*WIDTH +: WIDTH] = WIDTH'(m_cnt[c]);
                exp_tc[c]                   = m_tc[c];
            end
            n_tests++;
            if (count !== exp_count || tc !== exp_tc) begin
                n_fail++;
                $display("FAIL rand_%0d_count_tc: got %h/%b expected %h/%b",
                         k, count, tc, exp_count, exp_tc);
            end
            n_tests++;
            if (exp_valid !== m_ev || exp_idx !== IDX_W'(m_idx)) begin
                n_fail++;
                $display("FAIL rand_%0d_exp: got %b/%0d expected %b/%0d",
                         k, exp_valid, exp_idx, m_ev, m_idx);
            end
        end
        idle();
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        clear    = '0;
        load     = '0;
        inc      = '0;
        dec      = '0;
        load_val = '0;
        max_val  = '0;
        sat_mode = '0;
        model_reset();
        #1;
        test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        test_wrap_up();
        test_saturate();
        test_wrap_down();
        test_simultaneous_tc();
        test_load_clear_en();
        test_async_reset();
        // Bring the model and DUT into a known common state before random traffic.
        clear = '1;
        cycle();
        idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
